// File: rtl/hls_run_ctrl_pkg.sv
// Shared types and constants for the HLS run controller: FSM state encoding,
// default run-phase timeout and the fixed slave-port data width / access size.
package hls_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_WAIT = 3'd1,
        ST_LD_WR   = 3'd2,
        ST_START   = 3'd3,
        ST_RUN     = 3'd4,
        ST_REPORT  = 3'd5
    } state_t;

    localparam int         TIMEOUT_CYC_DEF = 200000000;
    localparam int         DATA_W          = 64;
    localparam int         SIZE_W          = 7;
    localparam logic [6:0] RAM_SIZE        = 7'd8;

endpackage

// File: rtl/hls_cycle_counter.sv
// 32-bit run-cycle counter: clear loads 1 (the START cycle counts as the first
// cycle), enable advances by one and the value sticks at all-ones.
module hls_cycle_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd1;
        end else if (enable && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/hls_run_ctrl.sv
// Session controller: optional byte preload through slave channel 0, one start
// pulse, then waits for done. Define HLS_RUN_CTRL_TIMEOUT_EN for a RUN timeout.
module hls_run_ctrl
    import hls_run_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              load_en,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              start_port,
    input  logic              done_port,
    output logic              S_we_ram,
    output logic              S_oe_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [SIZE_W-1:0] S_data_ram_size,
    input  logic              Sout_DataRdy,
    output logic              busy,
    output logic              res_valid,
    output logic              res_ok,
    output logic [31:0]       cycle_count,
    output logic [2:0]        dbg_state
);

    // Load beats move when ld_valid and ld_ready are both high at a rising
    // edge; ld_ready is only ever high in LD_WAIT, so beats elsewhere are dropped.
    state_t state;
    logic   last_q;
    logic   cnt_clr;
    logic   cnt_en;

    assign S_oe_ram        = 1'b0;
    assign S_data_ram_size = RAM_SIZE;
    assign dbg_state       = state;
    assign cnt_clr         = (state == ST_START);
    assign cnt_en          = (state == ST_RUN);

`ifdef HLS_RUN_CTRL_TIMEOUT_EN
    // Hitting this value in RUN means the increment lands exactly on TIMEOUT_CYC.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
`endif

    hls_cycle_counter u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .count  (cycle_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            last_q      <= 1'b0;
            ld_ready    <= 1'b0;
            start_port  <= 1'b0;
            S_we_ram    <= 1'b0;
            S_addr_ram  <= '0;
            S_Wdata_ram <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_ok      <= 1'b0;
        end else begin
            start_port <= 1'b0;
            res_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        busy <= 1'b1;
                        if (load_en) begin
                            state    <= ST_LD_WAIT;
                            ld_ready <= 1'b1;
                        end else begin
                            state      <= ST_START;
                            start_port <= 1'b1;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    if (ld_valid) begin
                        S_addr_ram  <= ld_addr;
                        S_Wdata_ram <= {{(DATA_W-8){1'b0}}, ld_data};
                        last_q      <= ld_last;
                        S_we_ram    <= 1'b1;
                        ld_ready    <= 1'b0;
                        state       <= ST_LD_WR;
                    end
                end
                ST_LD_WR: begin
                    if (Sout_DataRdy) begin
                        S_we_ram <= 1'b0;
                        if (last_q) begin
                            state      <= ST_START;
                            start_port <= 1'b1;
                        end else begin
                            state    <= ST_LD_WAIT;
                            ld_ready <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (done_port) begin
                        state     <= ST_REPORT;
                        res_valid <= 1'b1;
                        res_ok    <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (done_port) begin
                        state     <= ST_REPORT;
                        res_valid <= 1'b1;
                        res_ok    <= 1'b1;
                    end
`ifdef HLS_RUN_CTRL_TIMEOUT_EN
                    else if (cycle_count == TO_LAST) begin
                        state     <= ST_REPORT;
                        res_valid <= 1'b1;
                        res_ok    <= 1'b0;
                    end
`endif
                end
                ST_REPORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b0;
                    S_we_ram <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Bench for hls_run_ctrl: randomized sessions against a queue-based reference,
// plus directed preload, done-in-START, timeout and reset cases.
module tb_hls_run_ctrl;
    import hls_run_ctrl_pkg::*;

    localparam int AW = 9;
`ifdef HLS_RUN_CTRL_TIMEOUT_EN
    localparam int TB_TO = 50;
`else
    localparam int TB_TO = TIMEOUT_CYC_DEF;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          go, load_en, ld_valid, ld_ready, ld_last;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          start_port, done_port;
    logic          S_we_ram, S_oe_ram, Sout_DataRdy;
    logic [AW-1:0] S_addr_ram;
    logic [63:0]   S_Wdata_ram;
    logic [6:0]    S_data_ram_size;
    logic          busy, res_valid, res_ok;
    logic [31:0]   cycle_count;
    logic [2:0]    dbg_state;

    hls_run_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TB_TO)) dut (
        .clock(clock), .reset(reset), .go(go), .load_en(load_en),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .start_port(start_port),
        .done_port(done_port), .S_we_ram(S_we_ram), .S_oe_ram(S_oe_ram),
        .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size), .Sout_DataRdy(Sout_DataRdy),
        .busy(busy), .res_valid(res_valid), .res_ok(res_ok),
        .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [AW+7:0] wr_q[$];    // {addr, data} of each expected slave write
    logic [32:0]   res_q[$];   // {res_ok, cycle_count} of each expected result
    int vec_cnt = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    int ack_total = 0;
    int exp_acks = 0;
    int ack_dly = 2;
    logic [AW-1:0] beat_addr[4];
    logic [7:0]    beat_data[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave channel model ----------------
    initial begin
        int we_cyc = 0;
        Sout_DataRdy = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (S_we_ram) begin
                we_cyc++;
                Sout_DataRdy = (we_cyc == ack_dly + 1);
            end else begin
                we_cyc = 0;
                Sout_DataRdy = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prev_we = 1'b0;
        int   we_hi = 0;
        logic [AW+7:0] ew;
        logic [32:0]   er;
        forever begin
            @(negedge clock);
            if (S_we_ram && !prev_we) begin
                we_hi = 0;
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 64'(S_addr_ram), 64'(ew[AW+7:8]));
                    check("wr_data", S_Wdata_ram, {56'd0, ew[7:0]});
                    check("wr_size", 64'(S_data_ram_size), 64'd8);
                    check("wr_oe", 64'(S_oe_ram), 64'd0);
                end
            end
            if (S_we_ram) begin
                we_hi++;
                if (Sout_DataRdy) ack_total++;
            end
            if (!S_we_ram && prev_we) check("we_high_cycles", 64'(we_hi), 64'(ack_dly + 1));
            prev_we = S_we_ram;
            if (start_port) begin
                start_cnt++;
                check("start_after_acks", 64'(ack_total), 64'(exp_acks));
            end
            if (res_valid) begin
                if (res_q.size() == 0) check("res_unexpected", 1, 0);
                else begin
                    er = res_q.pop_front();
                    check("res_ok", 64'(res_ok), 64'(er[32]));
                    check("res_count", 64'(cycle_count), 64'(er[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (start_port) begin ok = 1'b1; break; end
        end
        if (!ok) check("start_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic pulse_go(input bit ld);
        @(posedge clock); #1;
        go = 1'b1; load_en = ld;
        @(posedge clock); #1;
        go = 1'b0; load_en = 1'b0;
    endtask

    task automatic send_beat(input logic [AW-1:0] a, input logic [7:0] d, input bit last);
        bit ok = 1'b0;
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ld_ready) begin
                @(posedge clock); #1;
                ok = 1'b1;
                break;
            end
        end
        ld_valid = 1'b0;
        if (!ok) check("ld_handshake_timeout", 0, 1);
    endtask

    // One full session; done_port rises dly cycles after the start pulse,
    // so the reported count is dly+1 (START cycle through done cycle).
    task automatic run_session(input bit ld, input int n, input int dly, input bit go_busy);
        int s0 = start_cnt;
        bit ok;
        exp_acks = ack_total + (ld ? n : 0);
        if (ld) for (int i = 0; i < n; i++) wr_q.push_back({beat_addr[i], beat_data[i]});
        res_q.push_back({1'b1, 32'(dly + 1)});
        // stray beats while idle must never reach the slave port
        @(posedge clock); #1;
        ld_valid = 1'b1; ld_addr = 9'(($urandom)); ld_data = 8'($urandom); ld_last = 1'b1;
        @(posedge clock); #1;
        ld_valid = 1'b0;
        pulse_go(ld);
        if (ld) begin
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
                send_beat(beat_addr[i], beat_data[i], i == n - 1);
            end
        end
        wait_start(ok);
        if (ok) begin
            for (int k = 0; k < dly; k++) begin
                go = (go_busy && k == 1);
                @(negedge clock);
            end
            go = 1'b0;
            done_port = 1'b1;
            @(negedge clock);
            done_port = 1'b0;
        end
        wait_idle(100);
        repeat (6) @(negedge clock);
        check("start_pulses", 64'(start_cnt - s0), 64'd1);
        check("res_pending", 64'(res_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"}, 64'(start_port), 0);
        check({tag, "_we"}, 64'(S_we_ram), 0);
        check({tag, "_ld_ready"}, 64'(ld_ready), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_res_valid"}, 64'(res_valid), 0);
        check({tag, "_res_ok"}, 64'(res_ok), 0);
        check({tag, "_count"}, 64'(cycle_count), 0);
        check({tag, "_addr"}, 64'(S_addr_ram), 0);
        check({tag, "_wdata"}, S_Wdata_ram, 0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int s0;
        reset = 1'b0; go = 1'b0; load_en = 1'b0; ld_valid = 1'b0;
        ld_addr = '0; ld_data = '0; ld_last = 1'b0; done_port = 1'b0;
        #2;
        check_reset_values("rst");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // no preload, done 10 cycles after start; a go while busy is dropped
        run_session(1'b0, 0, 10, 1'b1);

        // three-byte preload with a two-cycle acknowledge each
        ack_dly = 2;
        beat_addr[0] = 9'h000; beat_data[0] = 8'hA5;
        beat_addr[1] = 9'h001; beat_data[1] = 8'h3C;
        beat_addr[2] = 9'h07F; beat_data[2] = 8'hFF;
        run_session(1'b1, 3, 4, 1'b0);

        // done in the START cycle, then stray done pulses while idle
        run_session(1'b0, 0, 0, 1'b0);
        repeat (3) begin
            done_port = 1'b1; @(negedge clock);
            done_port = 1'b0; @(negedge clock);
        end
        check("idle_after_stray_done", 64'(busy), 0);

        // randomized sessions
        for (int t = 0; t < 12; t++) begin
            int n = $urandom_range(1, 4);
            ack_dly = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                beat_addr[i] = 9'($urandom_range(0, 511));
                beat_data[i] = 8'($urandom_range(0, 255));
            end
            run_session(1'($urandom_range(0, 1)), n, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end

        // done never arrives
        exp_acks = ack_total;
`ifdef HLS_RUN_CTRL_TIMEOUT_EN
        res_q.push_back({1'b0, 32'd50});
        pulse_go(1'b0);
        wait_idle(200);
        repeat (3) @(negedge clock);
        check("timeout_res_pending", 64'(res_q.size()), 0);
`else
        pulse_go(1'b0);
        repeat (1000) @(negedge clock);
        check("no_timeout_busy", 64'(busy), 1);
        #2 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
`endif

        // reset mid-RUN after a go pulse while busy
        s0 = start_cnt;
        pulse_go(1'b0);
        wait_start(ok);
        repeat (5) @(negedge clock);
        go = 1'b1; @(negedge clock);
        go = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_busy", 64'(busy), 1);
        #2 reset = 1'b0;
        #1 check_reset_values("async_rst");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check("post_reset_starts", 64'(start_cnt - s0), 64'd1);
        check("post_reset_busy", 64'(busy), 0);
        check("post_reset_res_pending", 64'(res_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
